// File: rtl/mux_pkg.sv
// Shared definitions for the packet-aware stream mux/demux pair:
// FSM state encoding and the source/select constants.
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    // Same encoding as the demux select, so src tags round-trip unchanged.
    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter, purely combinational.
// Always returns a one-hot grant; with zero or two requests the favoured one wins.
module rr_arbiter2
    import mux_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = (prio == SRC1) ? 2'b10 : 2'b01;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            default: gnt = (prio == SRC1) ? 2'b10 : 2'b01;
        endcase
    end

endmodule

// File: rtl/stream_mux_2to1.sv
// Packet-aware 2-to-1 valid/ready stream mux with round-robin arbitration.
// Grant is held for a whole packet; the output is a single register stage.
module stream_mux_2to1
    import mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    output logic             out_src,
    input  logic             out_ready
);

    state_e             state_q, state_d;
    logic               prio_q, prio_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               src_q, src_d;

    logic [1:0]         gnt;
    logic               can_load;
    logic               sel_src;
    logic               sel_valid;
    logic               sel_last;
    logic [WIDTH-1:0]   sel_data;
    logic               xfer;

    rr_arbiter2 u_arb (
        .req  ({in1_valid, in0_valid}),
        .prio (prio_q),
        .gnt  (gnt)
    );

    // The output register can accept a beat when empty or being drained this cycle.
    assign can_load = ~valid_q | out_ready;

    always_comb begin
        sel_src = SRC0;
        case (state_q)
            LOCK0:   sel_src = SRC0;
            LOCK1:   sel_src = SRC1;
            default: sel_src = (gnt == 2'b10) ? SRC1 : SRC0;
        endcase
    end

    assign sel_valid = (sel_src == SRC1) ? in1_valid : in0_valid;
    assign sel_last  = (sel_src == SRC1) ? in1_last  : in0_last;
    assign sel_data  = (sel_src == SRC1) ? in1_data  : in0_data;

    assign in0_ready = can_load & (sel_src == SRC0);
    assign in1_ready = can_load & (sel_src == SRC1);
    assign xfer      = sel_valid & can_load;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        src_d   = src_q;
        if (xfer) begin
            data_d  = sel_data;
            last_d  = sel_last;
            src_d   = sel_src;
            valid_d = 1'b1;
            // The packet's last beat releases the lock and hands priority to the other side.
            if (sel_last) begin
                state_d = IDLE;
                prio_d  = ~sel_src;
            end else begin
                state_d = (sel_src == SRC1) ? LOCK1 : LOCK0;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= SRC0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            src_q   <= SRC0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            src_q   <= src_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_src   = src_q;

endmodule

// File: tb/tb_stream_mux_2to1.sv
// Directed bench for stream_mux_2to1; output fields are compared packed as
// {out_valid, out_last, out_src, out_data} against hand-computed values.
module tb_stream_mux_2to1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in0_data = '0;
    logic       in0_valid = 1'b0;
    logic       in0_last = 1'b0;
    logic       in0_ready;
    logic [7:0] in1_data = '0;
    logic       in1_valid = 1'b0;
    logic       in1_last = 1'b0;
    logic       in1_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_src;
    logic       out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    stream_mux_2to1 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_last  (in0_last),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_last  (in1_last),
        .in1_ready (in1_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_last  = 1'b0;
        in1_last  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_last, out_src, out_data} !== 11'h000) begin
            errors++;
            $display("[TB] FAIL reset_outputs got=%h exp=%h", {out_valid, out_last, out_src, out_data}, 11'h000);
        end
        checks++;
        if ({in0_ready, in1_ready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL reset_ready got=%b exp=%b", {in0_ready, in1_ready}, 2'b10);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_source();
        logic [7:0] beats [3];
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
        for (int k = 0; k < 3; k++) begin
            in0_valid = 1'b1;
            in0_data  = beats[k];
            in0_last  = (k == 2);
            #1;
            checks++;
            if (in0_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL single_ready%0d got=%b exp=1", k, in0_ready);
            end
            step();
            checks++;
            if ({out_valid, out_last, out_src, out_data} !== {1'b1, (k == 2), 1'b0, beats[k]}) begin
                errors++;
                $display("[TB] FAIL single_beat%0d got=%h exp=%h", k,
                         {out_valid, out_last, out_src, out_data}, {1'b1, (k == 2), 1'b0, beats[k]});
            end
        end
        in0_valid = 1'b0;
        in0_last  = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_drain got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        in0_valid = 1'b1; in0_data = 8'hA0; in0_last = 1'b1;
        in1_valid = 1'b1; in1_data = 8'hB0; in1_last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if ({in0_ready, in1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("[TB] FAIL rr_ready%0d got=%b exp=%b", k, {in0_ready, in1_ready},
                         (k % 2 == 0) ? 2'b10 : 2'b01);
            end
            step();
            checks++;
            if ({out_valid, out_last, out_src, out_data} !==
                ((k % 2 == 0) ? {3'b110, 8'hA0} : {3'b111, 8'hB0})) begin
                errors++;
                $display("[TB] FAIL rr_beat%0d got=%h exp=%h", k, {out_valid, out_last, out_src, out_data},
                         (k % 2 == 0) ? {3'b110, 8'hA0} : {3'b111, 8'hB0});
            end
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        step();
    endtask

    task automatic test_packet_lock();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            in0_valid = 1'b1;
            in0_data  = 8'hD0 + 8'(k);
            in0_last  = (k == 3);
            if (k >= 1) begin
                in1_valid = 1'b1; in1_data = 8'hE0; in1_last = 1'b1;
            end
            #1;
            checks++;
            if ({in0_ready, in1_ready} !== 2'b10) begin
                errors++;
                $display("[TB] FAIL lock_ready%0d got=%b exp=10", k, {in0_ready, in1_ready});
            end
            step();
            checks++;
            if ({out_valid, out_last, out_src, out_data} !== {1'b1, (k == 3), 1'b0, 8'hD0 + 8'(k)}) begin
                errors++;
                $display("[TB] FAIL lock_beat%0d got=%h exp=%h", k, {out_valid, out_last, out_src, out_data},
                         {1'b1, (k == 3), 1'b0, 8'hD0 + 8'(k)});
            end
        end
        in0_valid = 1'b0;
        in0_last  = 1'b0;
        #1;
        checks++;
        if ({in0_ready, in1_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL lock_release got=%b exp=01", {in0_ready, in1_ready});
        end
        step();
        checks++;
        if ({out_valid, out_last, out_src, out_data} !== {3'b111, 8'hE0}) begin
            errors++;
            $display("[TB] FAIL lock_next got=%h exp=%h", {out_valid, out_last, out_src, out_data}, {3'b111, 8'hE0});
        end
        in1_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        in0_valid = 1'b1; in0_data = 8'h5C; in0_last = 1'b1;
        step();
        out_ready = 1'b0;
        in0_data  = 8'h6D;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({in0_ready, in1_ready} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL stall_ready%0d got=%b exp=00", k, {in0_ready, in1_ready});
            end
            step();
            checks++;
            if ({out_valid, out_last, out_src, out_data} !== {3'b110, 8'h5C}) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d got=%h exp=%h", k, {out_valid, out_last, out_src, out_data},
                         {3'b110, 8'h5C});
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in0_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_release got=%b exp=1", in0_ready);
        end
        step();
        checks++;
        if ({out_valid, out_last, out_src, out_data} !== {3'b110, 8'h6D}) begin
            errors++;
            $display("[TB] FAIL stall_nobubble got=%h exp=%h", {out_valid, out_last, out_src, out_data}, {3'b110, 8'h6D});
        end
        in0_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_packet();
        for (int k = 0; k < 2; k++) begin
            in1_valid = 1'b1; in1_data = 8'hF0 + 8'(k); in1_last = 1'b0;
            step();
        end
        checks++;
        if ({out_valid, out_last, out_src, out_data} !== {3'b101, 8'hF1}) begin
            errors++;
            $display("[TB] FAIL midrst_pre got=%h exp=%h", {out_valid, out_last, out_src, out_data}, {3'b101, 8'hF1});
        end
        in1_data  = 8'hF2;
        in0_valid = 1'b1; in0_data = 8'h77; in0_last = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_async got=%b exp=0", out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({in0_ready, in1_ready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL midrst_grant got=%b exp=10", {in0_ready, in1_ready});
        end
        step();
        checks++;
        if ({out_valid, out_last, out_src, out_data} !== {3'b110, 8'h77}) begin
            errors++;
            $display("[TB] FAIL midrst_first got=%h exp=%h", {out_valid, out_last, out_src, out_data}, {3'b110, 8'h77});
        end
        in0_valid = 1'b0;
        #1;
        checks++;
        if ({in0_ready, in1_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL midrst_in1 got=%b exp=01", {in0_ready, in1_ready});
        end
        step();
        checks++;
        if ({out_valid, out_last, out_src, out_data} !== {3'b101, 8'hF2}) begin
            errors++;
            $display("[TB] FAIL midrst_second got=%h exp=%h", {out_valid, out_last, out_src, out_data}, {3'b101, 8'hF2});
        end
        in1_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
